// File: rtl/btn_conditioner.sv
// Push-button conditioner: pad polarity fix, 2-flop synchronizer, and a
// per-channel debounce FSM producing a clean level plus press/release pulses.
module btn_conditioner #(
  parameter int unsigned      N_BTN           = 6,
  parameter int unsigned      DEBOUNCE_CYCLES = 250000,
  parameter int unsigned      CNT_W           = 18,
  parameter logic [N_BTN-1:0] INVERT_MASK     = '0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             any_press_o
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  state_t           state   [N_BTN];
  state_t           state_d [N_BTN];
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_d;

  // Polarity-corrected pad levels into a 2-flop synchronizer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw_i ^ INVERT_MASK;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: a candidate level must persist until the counter
  // reaches CNT_MAX; any contrary sample abandons it and clears the count.
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      state_d[i] = state[i];
      cnt_d[i]   = cnt[i];
      case (state[i])
        IDLE_LO: begin
          if (sync2[i]) begin
            state_d[i] = CHK_HI;
            cnt_d[i]   = '0;
          end
        end
        CHK_HI: begin
          if (!sync2[i]) begin
            state_d[i] = IDLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_d[i] = IDLE_HI;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt[i] + CNT_W'(1);
          end
        end
        IDLE_HI: begin
          if (!sync2[i]) begin
            state_d[i] = CHK_LO;
            cnt_d[i]   = '0;
          end
        end
        CHK_LO: begin
          if (sync2[i]) begin
            state_d[i] = IDLE_HI;
            cnt_d[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_d[i]   = IDLE_LO;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == IDLE_HI) || (state_d[i] == CHK_LO);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        state[i] <= IDLE_LO;
        cnt[i]   <= '0;
      end
      btn_level_o   <= '0;
      btn_press_o   <= '0;
      btn_release_o <= '0;
      any_press_o   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        state[i] <= state_d[i];
        cnt[i]   <= cnt_d[i];
      end
      btn_level_o   <= level_d;
      btn_press_o   <= press_d;
      btn_release_o <= release_d;
      any_press_o   <= |press_d;
    end
  end

endmodule
